mult_job_sequencer: RTL and testbench

Front-end job sequencer for the sequential signed shift-add multiplier. It accepts operand pairs over a valid/ready stream, buffers them in a small FIFO, and issues one start pulse per job to the multiplier. It captures each product on the rising edge of the multiplier's done and returns it on a valid/ready result stream. A per-job watchdog flags jobs whose done never arrives.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_operand_fifo.sv | 65 ++++++
 rtl/mult_job_sequencer.sv | 172 +++++++++++++++++
 tb/tb_mult_job_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier job sequencer: FSM encoding,
// default parameters and the FIFO occupancy width helper.
package mult_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

  // Occupancy must represent 0..depth inclusive, hence one extra bit.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mult_operand_fifo.sv
// Synchronous operand FIFO with occupancy count; pushes while full and
// pops while empty are dropped.
module mult_operand_fifo
  import mult_pkg::*;
#(
  parameter int DW    = 2 * DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DW-1:0]                 wdata,
  output logic [DW-1:0]                 rdata,
  output logic                          full,
  output logic                          empty,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mult_job_sequencer.sv
// Queues operand pairs, issues one start pulse per job to the shift-add
// multiplier, captures the product on done's rising edge and watchdogs each job.
module mult_job_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_a,
  input  logic [WIDTH-1:0]              in_b,
  output logic                          mul_start,
  output logic [WIDTH-1:0]              mul_a,
  output logic [WIDTH-1:0]              mul_b,
  input  logic                          mul_done,
  input  logic [2*WIDTH-1:0]            mul_product,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*WIDTH-1:0]            out_product,
  output logic                          out_timeout,
  output logic                          busy,
  output logic [count_width(DEPTH)-1:0] fifo_count
);

  localparam int CW  = count_width(DEPTH);
  localparam int PWD = 2 * WIDTH;
  localparam int WDW = $clog2(TIMEOUT) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  seq_state_e     state_r, state_s;
  logic [WDW-1:0] wd_r, wd_s;
  logic           done_q_r;
  logic           done_rise_s;

  logic           fifo_push_s;
  logic           fifo_pop_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [PWD-1:0] fifo_head_s;
  logic [CW-1:0]  fifo_count_s;

  logic           mul_start_r, mul_start_s;
  logic [WIDTH-1:0] mul_a_r, mul_a_s;
  logic [WIDTH-1:0] mul_b_r, mul_b_s;
  logic           out_valid_r, out_valid_s;
  logic [PWD-1:0] out_product_r, out_product_s;
  logic           out_timeout_r, out_timeout_s;

  assign fifo_push_s = in_valid & ~fifo_full_s;
  assign done_rise_s = mul_done & ~done_q_r;

  mult_operand_fifo #(
    .DW    (PWD),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .wdata ({in_a, in_b}),
    .rdata (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Next-state and next-output logic; defaults hold every register.
  always_comb begin
    state_s       = state_r;
    wd_s          = wd_r;
    fifo_pop_s    = 1'b0;
    mul_start_s   = 1'b0;
    mul_a_s       = mul_a_r;
    mul_b_s       = mul_b_r;
    out_valid_s   = out_valid_r;
    out_product_s = out_product_r;
    out_timeout_s = out_timeout_r;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s  = 1'b1;
          mul_a_s     = fifo_head_s[PWD-1:WIDTH];
          mul_b_s     = fifo_head_s[WIDTH-1:0];
          wd_s        = {WDW{1'b0}};
          mul_start_s = 1'b1;
          state_s     = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        wd_s = wd_r + WDW'(1);
        // A real edge beats a coincident watchdog expiry.
        if (done_rise_s) begin
          out_product_s = mul_product;
          out_timeout_s = 1'b0;
          out_valid_s   = 1'b1;
          state_s       = ST_HOLD;
        end else if (wd_s == WD_LAST) begin
          out_product_s = {PWD{1'b0}};
          out_timeout_s = 1'b1;
          out_valid_s   = 1'b1;
          state_s       = ST_HOLD;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (out_valid_r && out_ready) begin
          out_valid_s = 1'b0;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, watchdog and done history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      wd_r     <= {WDW{1'b0}};
      done_q_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      wd_r     <= wd_s;
      done_q_r <= mul_done;
    end
  end

  // Registered outputs towards the multiplier and the result stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_start_r   <= 1'b0;
      mul_a_r       <= {WIDTH{1'b0}};
      mul_b_r       <= {WIDTH{1'b0}};
      out_valid_r   <= 1'b0;
      out_product_r <= {PWD{1'b0}};
      out_timeout_r <= 1'b0;
    end else begin
      mul_start_r   <= mul_start_s;
      mul_a_r       <= mul_a_s;
      mul_b_r       <= mul_b_s;
      out_valid_r   <= out_valid_s;
      out_product_r <= out_product_s;
      out_timeout_r <= out_timeout_s;
    end
  end

  assign mul_start   = mul_start_r;
  assign mul_a       = mul_a_r;
  assign mul_b       = mul_b_r;
  assign out_valid   = out_valid_r;
  assign out_product = out_product_r;
  assign out_timeout = out_timeout_r;
  // Status flags are decoded straight from registered state.
  assign in_ready    = ~fifo_full_s;
  assign busy        = (state_r != ST_IDLE) | ~fifo_empty_s;
  assign fifo_count  = fifo_count_s;

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Directed bench for mult_job_sequencer with a behavioural multiplier model
// and an in-order result scoreboard.
module tb_mult_job_sequencer;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 4;
  localparam int TIMEOUT  = 64;
  localparam int M_NORMAL = 0;
  localparam int M_ZERO   = 1;
  localparam int M_STICKY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_done;
  logic [63:0] mul_product;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_product;
  logic        out_timeout;
  logic        busy;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_job_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_start(mul_start), .mul_a(mul_a),
    .mul_b(mul_b), .mul_done(mul_done), .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .out_timeout(out_timeout), .busy(busy), .fifo_count(fifo_count)
  );

  // Multiplier model: done rises 34 edges after start is sampled, stays high until next start.
  int          mode = M_NORMAL;
  logic        ovr_en = 1'b0;
  logic        ovr_done = 1'b0;
  logic        done_m;
  int          cnt_m;
  logic [63:0] prod_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      done_m <= 1'b0;
      cnt_m  <= 0;
      prod_m <= 64'd0;
    end else if (mul_start) begin
      done_m <= 1'b0;
      cnt_m  <= 34;
      prod_m <= $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
    end else if (cnt_m > 1) begin
      cnt_m <= cnt_m - 1;
    end else if (cnt_m == 1) begin
      done_m <= 1'b1;
      cnt_m  <= 0;
    end
  end

  assign mul_done    = ovr_en ? ovr_done :
                       (mode == M_ZERO) ? 1'b0 :
                       (mode == M_STICKY) ? 1'b1 : done_m;
  assign mul_product = ovr_en ? 64'hDEAD_BEEF_0BAD_F00D : prod_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Scoreboard and event monitor, sampled just after the falling edge.
  logic [63:0] exp_p[$];
  logic        exp_t[$];
  int          n_results = 0;
  int          n_starts = 0;
  int          last_start_cyc = 0;
  int          valid_rise_cyc = 0;
  int          max_count = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] start_a = 32'd0;
  logic [31:0] start_b = 32'd0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mul_start === 1'b1) begin
        n_starts++;
        last_start_cyc = cyc;
        start_a = mul_a;
        start_b = mul_b;
      end
      if (out_valid === 1'b1 && !prev_valid) valid_rise_cyc = cyc;
      prev_valid = (out_valid === 1'b1);
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
      if (out_valid === 1'b1 && out_ready && !rst) begin
        n_results++;
        check("result_expected", 64'(exp_p.size() != 0), 64'd1);
        if (exp_p.size() != 0) begin
          check("product", out_product, exp_p.pop_front());
          check("timeout_flag", 64'(out_timeout), 64'(exp_t.pop_front()));
        end
      end
    end
  end

  task automatic expect_result(input logic [63:0] p, input logic t);
    exp_p.push_back(p);
    exp_t.push_back(t);
  endtask

  // Called at a falling edge; holds the pair until accepted.
  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, output int acc_cyc);
    int g = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) check("push_accept_deadline", 64'(in_ready), 64'd1);
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int target);
    int g = 0;
    while (n_results < target && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("results_by_deadline", 64'(n_results), 64'(target));
  endtask

  task automatic wait_valid();
    int g = 0;
    while (out_valid !== 1'b1 && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("valid_by_deadline", 64'(out_valid), 64'd1);
  endtask

  initial begin
    int pc;
    int base;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_mul_start", 64'(mul_start), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_product", out_product, 64'd0);
    check("rst_out_timeout", 64'(out_timeout), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);

    // Basic signed job: 3 * -4.
    out_ready = 1'b1;
    n_starts = 0;
    expect_result(64'hFFFF_FFFF_FFFF_FFF4, 1'b0);
    push_pair(32'd3, 32'hFFFF_FFFC, pc);
    wait_results(1);
    check("basic_latency", 64'(valid_rise_cyc - pc), 64'd38);
    check("basic_starts", 64'(n_starts), 64'd1);
    check("basic_mul_a", 64'(start_a), 64'd3);
    check("basic_mul_b", 64'(start_b), 64'hFFFF_FFFC);

    // Back-to-back jobs.
    n_starts = 0;
    max_count = 0;
    expect_result(64'd42, 1'b0);
    expect_result(64'd25, 1'b0);
    expect_result(64'h0000_0000_FFFF_FFFE, 1'b0);
    push_pair(32'd7, 32'd6, pc);
    push_pair(32'hFFFF_FFFB, 32'hFFFF_FFFB, pc);
    push_pair(32'h7FFF_FFFF, 32'd2, pc);
    wait_results(4);
    check("b2b_starts", 64'(n_starts), 64'd3);
    check("b2b_peak_count", 64'(max_count), 64'd2);

    // Backpressure: six jobs with the result stream stalled.
    out_ready = 1'b0;
    base = n_results;
    expect_result(64'd2, 1'b0);
    expect_result(64'd12, 1'b0);
    expect_result(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    expect_result(64'hFFFF_FFFF_FFFF_FFE2, 1'b0);
    expect_result(64'd10000, 1'b0);
    expect_result(64'd56, 1'b0);
    fork
      begin
        int c;
        push_pair(32'd1, 32'd2, c);
        push_pair(32'd3, 32'd4, c);
        push_pair(32'hFFFF_FFFF, 32'd1, c);
        push_pair(32'd5, 32'hFFFF_FFFA, c);
        push_pair(32'd100, 32'd100, c);
        push_pair(32'hFFFF_FFF9, 32'hFFFF_FFF8, c);
      end
      begin
        repeat (50) @(negedge clk);
        check("bp_fifo_full_count", 64'(fifo_count), 64'd4);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_product", out_product, 64'd2);
        out_ready = 1'b1;
      end
    join
    wait_results(base + 6);

    // Watchdog: done never arrives.
    mode = M_ZERO;
    expect_result(64'd0, 1'b1);
    push_pair(32'd1, 32'd1, pc);
    wait_results(base + 7);
    check("timeout_latency", 64'(valid_rise_cyc - last_start_cyc), 64'(TIMEOUT));
    mode = M_NORMAL;
    repeat (2) @(negedge clk);
    expect_result(64'd6, 1'b0);
    push_pair(32'd2, 32'd3, pc);
    wait_results(base + 8);

    // Sticky done: high before ISSUE, no edge, so the job times out.
    mode = M_STICKY;
    repeat (3) @(negedge clk);
    expect_result(64'd0, 1'b1);
    push_pair(32'd4, 32'd4, pc);
    wait_results(base + 9);
    mode = M_NORMAL;
    repeat (2) @(negedge clk);

    // A done edge while holding a result must not recapture.
    out_ready = 1'b0;
    expect_result(64'd81, 1'b0);
    push_pair(32'd9, 32'd9, pc);
    wait_valid();
    ovr_en = 1'b1;
    ovr_done = 1'b0;
    repeat (2) @(negedge clk);
    ovr_done = 1'b1;
    repeat (2) @(negedge clk);
    check("hold_product", out_product, 64'd81);
    check("hold_valid", 64'(out_valid), 64'd1);
    check("hold_timeout", 64'(out_timeout), 64'd0);
    ovr_en = 1'b0;
    out_ready = 1'b1;
    wait_results(base + 10);

    // Reset mid-WAIT with two entries queued.
    push_pair(32'd11, 32'd11, pc);
    push_pair(32'd12, 32'd12, pc);
    push_pair(32'd13, 32'd13, pc);
    repeat (10) @(negedge clk);
    check("pre_reset_count", 64'(fifo_count), 64'd2);
    check("pre_reset_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_fifo_count", 64'(fifo_count), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_mul_start", 64'(mul_start), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    base = n_results;
    n_starts = 0;
    repeat (100) @(negedge clk);
    check("post_rst_no_result", 64'(n_results), 64'(base));
    check("post_rst_no_start", 64'(n_starts), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
